mf_trigger_ctrl: RTL

Sequencing and trigger controller for the two-sample-per-clock systolic matched filter chain (systA/B/C).
- Forces the filter inputs to zero to flush stale pipeline history, and tracks pipeline fill latency.
- Qualifies the full-filter outputs (out0/out1) as valid.
- Runs a signed threshold compare with holdoff to produce trigger pulses for the downstream trigger logic.
- Sits between the ADC sample stream front-end and the matched filter chain, and on the matched filter output side.

---
 rtl/mf_trigger_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mf_trigger_ctrl.sv
// rtl/mf_trigger_ctrl.sv - flush/fill sequencing, output qualification and threshold trigger for the matched filter chain (optional trigger counter: MF_TRIG_COUNT_EN)
module mf_trigger_ctrl #(
  parameter int OUTBITS      = 16,
  parameter int LATENCY      = 9,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    in_valid_i,
  input  logic [OUTBITS-1:0]      thresh_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [OUTBITS-1:0]      mf0_i,
  input  logic [OUTBITS-1:0]      mf1_i,
  output logic                    zero_o,
  output logic                    out_valid_o,
  output logic                    trig_o,
  output logic                    trig_idx_o,
  output logic [OUTBITS-1:0]      trig_val_o,
  output logic [1:0]              state_o,
  output logic [15:0]             trig_count_o
);

  localparam int CNTW = $clog2(LATENCY + 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(LATENCY);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [HOLDOFF_BITS-1:0] holdoff_q, holdoff_d;
  logic                    zero_q, zero_d;
  logic                    out_valid_q, out_valid_d;
  logic                    trig_q, trig_d;
  logic                    trig_idx_q, trig_idx_d;
  logic [OUTBITS-1:0]      trig_val_q, trig_val_d;
  logic                    hit0, hit1;

  assign hit0 = $signed(mf0_i) >= $signed(thresh_i);
  assign hit1 = $signed(mf1_i) >= $signed(thresh_i);

  // Next state and flush/fill counter; enable low overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
        FLUSH: begin
          if (cnt_q == CNT_MAX) begin
            if (in_valid_i) begin
              state_d = FILL;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FILL: begin
          if (!in_valid_i) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!in_valid_i) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Threshold compare with holdoff; mf0 is earlier in time so it wins ties
  always_comb begin
    trig_d     = 1'b0;
    trig_idx_d = trig_idx_q;
    trig_val_d = trig_val_q;
    holdoff_d  = (holdoff_q != '0) ? holdoff_q - 1'b1 : holdoff_q;
    if (enable_i && (state_q == RUN) && (holdoff_q == '0) && (hit0 || hit1)) begin
      trig_d     = 1'b1;
      trig_idx_d = ~hit0;
      trig_val_d = hit0 ? mf0_i : mf1_i;
      holdoff_d  = holdoff_i;
    end
    if (!enable_i) begin
      holdoff_d = '0;
    end
  end

  // Flush and valid flags; valid only once RUN has been held across a clock
  always_comb begin
    zero_d      = (state_d == IDLE) || (state_d == FLUSH);
    out_valid_d = (state_q == RUN) && (state_d == RUN);
  end

  // State, counters and every registered output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      holdoff_q   <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      trig_q      <= 1'b0;
      trig_idx_q  <= 1'b0;
      trig_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      holdoff_q   <= holdoff_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      trig_q      <= trig_d;
      trig_idx_q  <= trig_idx_d;
      trig_val_q  <= trig_val_d;
    end
  end

`ifdef MF_TRIG_COUNT_EN
  logic [15:0] trig_count_q;

  // Saturating trigger counter, cleared whenever the controller sits in IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_count_q <= '0;
    end else if (state_d == IDLE) begin
      trig_count_q <= '0;
    end else if (trig_d && (trig_count_q != 16'hFFFF)) begin
      trig_count_q <= trig_count_q + 16'd1;
    end
  end

  assign trig_count_o = trig_count_q;
`else
  assign trig_count_o = 16'h0000;
`endif

  assign zero_o      = zero_q;
  assign out_valid_o = out_valid_q;
  assign trig_o      = trig_q;
  assign trig_idx_o  = trig_idx_q;
  assign trig_val_o  = trig_val_q;
  assign state_o     = state_q;

endmodule
